// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, the NOP encoding,
// the default reset vector and the next-PC select codes.
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_W             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JMP,
    SEL_BR
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage. Branch beats stall beats jump
// beats sequential; also produces the IF/ID flush and hold strobes.
module fetch_pc_sel
  import mips_pkg::*;
(
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic        i_jmp_taken,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_br_target,
  input  logic [3:0]  i_pc4_hi,
  input  logic [25:0] i_jmp_index,
  output logic [31:0] o_next_pc,
  output logic        o_flush,
  output logic        o_hold
);

  pc_sel_e w_sel;

  // The branch is resolved in EX and is older than anything in ID, so it
  // overrides both a stall and a jump sitting in decode.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    w_sel = SEL_SEQ;
    if (i_br_taken) begin
      w_sel = SEL_BR;
    end else if (i_stall) begin
      w_sel = SEL_HOLD;
    end else if (i_jmp_taken) begin
      w_sel = SEL_JMP;
    end
  end

  always_comb begin
    o_next_pc = i_pc + 32'd4;
    o_flush   = 1'b0;
    o_hold    = 1'b0;
    case (w_sel)
      SEL_BR: begin
        o_next_pc = i_br_target & 32'hFFFF_FFFC;
        o_flush   = 1'b1;
      end
      SEL_HOLD: begin
        o_next_pc = i_pc;
        o_hold    = 1'b1;
      end
      SEL_JMP: begin
        o_next_pc = {i_pc4_hi, i_jmp_index, 2'b00};
        o_flush   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word address to the ROM and the
// IF/ID pipeline register, with stall and branch/jump redirect handling.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] if_address,
  input  logic [31:0]       if_data,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp_taken,
  input  logic [25:0]       jmp_index,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic              pc_oob
);

  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc4;
  logic               r_ifid_valid;

  logic [PC_W-1:0]    w_next_pc;
  logic [PC_W-1:0]    w_pc_plus4;
  logic               w_flush;
  logic               w_hold;

  assign w_pc_plus4 = r_pc + 32'd4;

  fetch_pc_sel u_pc_sel (
    .i_stall     (stall),
    .i_br_taken  (br_taken),
    .i_jmp_taken (jmp_taken),
    .i_pc        (r_pc),
    .i_br_target (br_target),
    .i_pc4_hi    (r_ifid_pc4[31:28]),
    .i_jmp_index (jmp_index),
    .o_next_pc   (w_next_pc),
    .o_flush     (w_flush),
    .o_hold      (w_hold)
  );

  // Reset wins over stall and redirects; the selector already folds hold
  // into w_next_pc, so the PC loads unconditionally out of reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_flush) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc4   <= '0;
        r_ifid_valid <= 1'b0;
      end else if (!w_hold) begin
        r_ifid_instr <= if_data;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  // Upper PC bits are dropped by the word address, so a non-zero upper
  // field means the fetch is aliasing back into the ROM.
  assign if_address = r_pc[ADDR_W+1:2];
  assign pc_oob     = |r_pc[PC_W-1:ADDR_W+2];

  assign pc         = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] if_address;
  logic [31:0]       if_data;
  logic              stall;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              jmp_taken;
  logic [25:0]       jmp_index;
  logic [31:0]       pc;
  logic [31:0]       ifid_instr;
  logic [31:0]       ifid_pc4;
  logic              ifid_valid;
  logic              pc_oob;

  logic [31:0] rom [0:63];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what the architecture says the fetch stage holds.
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  always #5 clk = ~clk;

  assign if_data = rom[if_address];

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_address (if_address),
    .if_data    (if_data),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_taken  (jmp_taken),
    .jmp_index  (jmp_index),
    .pc         (pc),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .pc_oob     (pc_oob)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one architectural step per rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_known <= 1'b1;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
      m_pc4   <= 32'h0;
      m_valid <= 1'b0;
    end else if (m_known) begin
      if (br_taken) begin
        m_pc    <= br_target - (br_target % 4);
        m_instr <= 32'h0;
        m_pc4   <= 32'h0;
        m_valid <= 1'b0;
      end else if (stall) begin
        m_pc <= m_pc;
      end else if (jmp_taken) begin
        m_pc    <= (m_pc4 & 32'hF000_0000) + (32'(jmp_index) * 4);
        m_instr <= 32'h0;
        m_pc4   <= 32'h0;
        m_valid <= 1'b0;
      end else begin
        m_instr <= rom[(m_pc / 4) % 64];
        m_pc4   <= m_pc + 32'd4;
        m_valid <= 1'b1;
        m_pc    <= m_pc + 32'd4;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("pc", pc, m_pc);
      check("if_address", 32'(if_address), (m_pc / 4) % 64);
      check("pc_oob", 32'(pc_oob), 32'(m_pc >= 32'd256));
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pc4", ifid_pc4, m_pc4);
      check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    end
  end

  // Apply one cycle of inputs at the falling edge, then settle after the rise.
  task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                       input logic jt, input logic [25:0] ji);
    @(negedge clk);
    reset_n   = rst;
    stall     = st;
    br_taken  = br;
    br_target = bt;
    jmp_taken = jt;
    jmp_index = ji;
    @(posedge clk);
    #1;
  endtask

  task automatic free_cycle();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h2002_0005;
    rom[1] = 32'h2003_000c;
    rom[2] = 32'h2067_fff7;
    rom[3] = 32'h00e2_2025;

    reset_n   = 1'b0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    jmp_taken = 1'b0;
    jmp_index = 26'h0;

    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    check("lit reset pc", pc, 32'h0);
    check("lit reset valid", 32'(ifid_valid), 32'h0);
    check("lit reset instr", ifid_instr, 32'h0);
    check("lit first if_address", 32'(if_address), 32'h0);

    // Sequential fetch
    free_cycle();
    check("lit seq0 instr", ifid_instr, 32'h2002_0005);
    check("lit seq0 pc4", ifid_pc4, 32'h4);
    check("lit seq0 valid", 32'(ifid_valid), 32'h1);
    check("lit seq1 if_address", 32'(if_address), 32'h1);
    free_cycle();
    check("lit seq1 instr", ifid_instr, 32'h2003_000c);
    check("lit seq1 pc", pc, 32'h8);

    // Two stalled edges with pc=8
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 26'h3);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    check("lit stall pc", pc, 32'h8);
    check("lit stall instr", ifid_instr, 32'h2003_000c);
    check("lit stall pc4", ifid_pc4, 32'h8);
    free_cycle();
    check("lit resume instr", ifid_instr, 32'h2067_fff7);
    check("lit resume pc4", ifid_pc4, 32'hC);
    free_cycle();
    check("lit resume2 instr", ifid_instr, 32'h00e2_2025);
    check("lit resume2 pc4", ifid_pc4, 32'h10);

    // Branch to 0x3C, one free edge -> ifid_pc4 = 0x40, then jump
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_003C, 1'b0, 26'h0);
    check("lit br flush valid", 32'(ifid_valid), 32'h0);
    free_cycle();
    check("lit pre-jump pc4", ifid_pc4, 32'h40);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h11);
    check("lit jump pc", pc, 32'h44);
    check("lit jump valid", 32'(ifid_valid), 32'h0);
    check("lit jump instr", ifid_instr, 32'h0);
    free_cycle();
    check("lit jump target instr", ifid_instr, rom[17]);
    check("lit jump target pc4", ifid_pc4, 32'h48);

    // Branch beats jump and stall
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_002B, 1'b1, 26'h5);
    check("lit br prio pc", pc, 32'h28);
    check("lit br prio valid", 32'(ifid_valid), 32'h0);
    check("lit br prio instr", ifid_instr, 32'h0);

    // Held branch is idempotent
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 26'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 26'h0);
    check("lit held br pc", pc, 32'h80);

    // Aliasing and wrap
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'h0);
    check("lit alias if_address", 32'(if_address), 32'h0);
    check("lit alias oob", 32'(pc_oob), 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    check("lit top pc", pc, 32'hFFFF_FFFC);
    check("lit top oob", 32'(pc_oob), 32'h1);
    free_cycle();
    check("lit wrap pc", pc, 32'h0);
    check("lit wrap oob", 32'(pc_oob), 32'h0);
    check("lit wrap instr", ifid_instr, rom[63]);
    check("lit wrap pc4", ifid_pc4, 32'h0);

    // Reset mid-stall with a branch pending
    free_cycle();
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b0, 26'h0);
    check("lit midrst pc", pc, 32'h0);
    check("lit midrst valid", 32'(ifid_valid), 32'h0);
    check("lit midrst instr", ifid_instr, 32'h0);
    free_cycle();
    check("lit post-rst instr", ifid_instr, 32'h2002_0005);
    check("lit post-rst valid", 32'(ifid_valid), 32'h1);
    check("lit post-rst pc", pc, 32'h4);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 800; n++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_br;
      logic        r_jt;
      logic [31:0] r_bt;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_st  = ($urandom_range(0, 99) < 25);
      r_br  = ($urandom_range(0, 99) < 12);
      r_jt  = ($urandom_range(0, 99) < 15);
      r_bt  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      cycle(r_rst, r_st, r_br, r_bt, r_jt, 26'($urandom));
    end

    free_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Holds the program counter and drives the word address into the instruction memory ROM (combinational read, word-addressed).
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Applies hazard-unit stalls and branch/jump redirects, flushing the wrong-path slot on a redirect.

Parameters:
- ADDR_W, 6, instruction memory word-address width; if_address = pc[ADDR_W+1:2].
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- if_address  output  ADDR_W  word address to instruction memory (pc[ADDR_W+1:2]).
- if_data  input  32  instruction returned combinationally by instruction memory.
- stall  input  1  hazard unit: hold PC and IF/ID.
- br_taken  input  1  branch resolved taken in EX.
- br_target  input  32  branch target byte address; bits [1:0] are ignored.
- jmp_taken  input  1  J-type instruction decoded in ID.
- jmp_index  input  26  J-type instr_index field.
- pc  output  32  current PC.
- ifid_instr  output  32  IF/ID instruction register.
- ifid_pc4  output  32  IF/ID PC+4 of the captured instruction.
- ifid_valid  output  1  IF/ID holds a real (non-squashed) instruction.
- pc_oob  output  1  pc[31:ADDR_W+2] != 0; the fetch address has wrapped inside the ROM.

Behaviour:
- Reset (reset_n=0 at edge):
  - pc=RESET_PC, ifid_instr=32'h00000000 (NOP), ifid_pc4=0, ifid_valid=0.
  - Reset dominates all other inputs, including mid-stall and mid-redirect.
- Combinational outputs:
  - if_address = pc[ADDR_W+1:2].
  - pc_oob is derived from pc.
  - No other combinational paths from inputs to outputs.
- Next-PC selection, in priority order:
  1. br_taken=1: pc <= {br_target[31:2],2'b00}. Overrides stall and jmp_taken, because the branch is the older instruction.
  2. stall=1: pc holds. jmp_taken is ignored; the jump stays in ID and acts once stall drops.
  3. jmp_taken=1: pc <= {ifid_pc4[31:28], jmp_index, 2'b00}.
  4. Otherwise: pc <= pc + 4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- IF/ID register update, same priority:
  1. br_taken: ifid_instr <= NOP, ifid_pc4 <= 0, ifid_valid <= 0 (flush).
  2. stall: all three hold.
  3. jmp_taken: flush the slot fetched behind the jump (NOP, valid=0).
  4. Otherwise: ifid_instr <= if_data, ifid_pc4 <= pc+4, ifid_valid <= 1.
- Latency:
  - The instruction at PC P appears on ifid_instr one edge after pc=P, with no stall.
  - Redirect penalty: 1 bubble for a jump.
  - For a branch, the slot flushed in IF/ID is the only one this block squashes; the ID-stage instruction is flushed by the downstream stage.
- First cycle after reset release: if_address=RESET_PC[ADDR_W+1:2]. The first edge captures ROM[RESET_PC>>2] with valid=1.
- ROM aliasing: addresses above 4*2^ADDR_W alias by truncation. Fetch continues, pc_oob=1, and no exception is raised.
- Simultaneous br_taken and jmp_taken: the branch wins and the jump is discarded.
- stall and a redirect both held over several cycles: each edge is re-evaluated independently. A held br_taken re-loads the same target (idempotent).

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h00000000.
  - INSTR_W = 32.
  - PC_W = 32.
  - Default RESET_PC.
  - Local enum for next-PC select {SEL_SEQ, SEL_HOLD, SEL_JMP, SEL_BR}.
- One combinational sub-module, fetch_pc_sel:
  - Computes the select code, next_pc and the flush/hold strobes from stall/br_taken/jmp_taken.
- The top level holds the PC and IF/ID registers.

Test Plan:
- Sequential fetch: ROM[0..3]=20020005, 2003000c, 2067fff7, 00e22025; release reset -> if_address 0,1,2,3 on successive cycles; ifid_instr follows one edge later with ifid_pc4=4,8,12,16 and ifid_valid=1.
- Stall: assert stall for 2 cycles with pc=8 -> pc stays 8 and ifid_instr stays 2003000c for 2 edges; sequential fetch resumes afterwards with no lost or duplicated instruction.
- Jump: ifid_pc4=32'h00000040, jmp_taken=1, jmp_index=26'h11 -> next pc=32'h00000044, ifid_valid=0 and ifid_instr=0 for one edge; then ROM[17] is captured.
- Branch vs jump vs stall: br_taken=1, br_target=32'h0000002B, jmp_taken=1, stall=1 in the same cycle -> pc=32'h00000028 and the IF/ID slot is flushed.
- Wrap/aliasing: force a branch to 32'h00000100 -> if_address=0, pc_oob=1; branch to 32'hFFFFFFFC, then one free cycle -> pc=0 and pc_oob=0.
- Reset mid-operation: reset_n=0 for one edge during a stall with br_taken high -> pc=RESET_PC, ifid_valid=0, ifid_instr=0; normal fetch from RESET_PC resumes on the next edge.
